// File: rtl/fetch_stage.sv
// fetch_stage: PC, imem read, F/D register, 2-word instruction assembly.
// Optional boot-vector fetch enabled by defining FETCH_RESET_VECTOR_EN.
module fetch_stage #(
  parameter int PC_W = 32,
  parameter int INSTR_W = 16,
  parameter int IMM_BIT = 15,
  parameter int SRC_LSB = 7,
  parameter int DST_LSB = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               pc_enb,
  input  logic               fd_enb,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               fd_valid,
  output logic [INSTR_W-1:0] fd_instr,
  output logic [INSTR_W-1:0] fd_imm,
  output logic [PC_W-1:0]    fd_pc,
  output logic [2:0]         src_F_D,
  output logic [2:0]         dst_F_D
);

  typedef enum logic [1:0] {
`ifdef FETCH_RESET_VECTOR_EN
    BOOT_LO   = 2'd0,
    BOOT_HI   = 2'd1,
`endif
    FETCH     = 2'd2,
    FETCH_IMM = 2'd3
  } state_t;

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] hold_op;
  logic [PC_W-1:0]    hold_pc;
  logic               stall;

`ifdef FETCH_RESET_VECTOR_EN
  logic [INSTR_W-1:0]   vec_lo;
  logic [2*INSTR_W-1:0] vec;
  assign vec = {imem_rdata, vec_lo};
`endif

  assign imem_addr = pc;
  assign stall     = !pc_enb || !fd_enb;
  assign src_F_D   = fd_instr[SRC_LSB+:3];
  assign dst_F_D   = fd_instr[DST_LSB+:3];

  // PC / state / F/D update: rst > branch > stall > normal fetch
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef FETCH_RESET_VECTOR_EN
      state  <= BOOT_LO;
      pc     <= '0;
      vec_lo <= '0;
`else
      state  <= FETCH;
      pc     <= RESET_PC;
`endif
      hold_op  <= '0;
      hold_pc  <= '0;
      fd_valid <= 1'b0;
      fd_instr <= '0;
      fd_imm   <= '0;
      fd_pc    <= '0;
    end else begin
      case (state)
`ifdef FETCH_RESET_VECTOR_EN
        BOOT_LO: begin
          vec_lo <= imem_rdata;
          pc     <= PC_W'(1);
          state  <= BOOT_HI;
        end
        BOOT_HI: begin
          pc    <= PC_W'(vec);
          state <= FETCH;
        end
`endif
        FETCH, FETCH_IMM: begin
          if (branch_taken) begin
            pc       <= branch_target;
            state    <= FETCH;
            hold_op  <= '0;
            hold_pc  <= '0;
            fd_valid <= 1'b0;
            fd_instr <= '0;
            fd_imm   <= '0;
            fd_pc    <= '0;
          end else if (!stall) begin
            pc <= pc + PC_W'(1);
            if (state == FETCH_IMM) begin
              fd_valid <= 1'b1;
              fd_instr <= hold_op;
              fd_imm   <= imem_rdata;
              fd_pc    <= hold_pc;
              state    <= FETCH;
            end else if (imem_rdata[IMM_BIT]) begin
              hold_op  <= imem_rdata;
              hold_pc  <= pc;
              fd_valid <= 1'b0;
              state    <= FETCH_IMM;
            end else begin
              fd_valid <= 1'b1;
              fd_instr <= imem_rdata;
              fd_imm   <= '0;
              fd_pc    <= pc;
            end
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
